mem_responder: RTL
==================

# mem_responder

Memory-side responder for the multi-cycle RV32I core. It serves the control unit's MemoryRead/MemoryWrite requests from a single unified instruction/data word array. It handles byte, halfword and word sizing, sign/zero extension and a programmable access latency, and signals completion with a one-cycle `done` pulse so the control FSM can advance.

## Interface
Parameters:
- `DEPTH`, 1024 — number of 32-bit words; address index = `addr[$clog2(DEPTH)+1:2]`, upper bits ignored
- `WAIT_CYCLES`, 1 — extra access cycles between accept and response; range 0–15

Ports:
- `clk` in 1 — the single clock, rising edge
- `clr` in 1 — reset, asynchronous, active-high
- `MemoryRead` in 1 — read request, level, sampled only in IDLE
- `MemoryWrite` in 1 — write request, level, sampled only in IDLE
- `addr` in 32 — byte address
- `wdata` in 32 — store data, right-aligned
- `func3` in 3 — access size/sign (RV32I load/store encoding)
- `rdata` out 32 — load result, extended; held until next read completion
- `done` out 1 — one-cycle pulse: request finished (read data valid or write committed)
- `busy` out 1 — high from the accept cycle until the cycle after `done`
- `err` out 1 — one-cycle pulse in place of `done` for a rejected request

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if exactly one of `MemoryRead`/`MemoryWrite` is high, latch `addr`, `wdata`, `func3` and direction, load wait counter with `WAIT_CYCLES`, and go to ACCESS.
- If both are high: go to RESP with the error flag set; no array access.
- ACCESS: decrement the counter. At 0, perform the array access and go to RESP. With `WAIT_CYCLES`=0, ACCESS lasts exactly one cycle.
- RESP: assert `done` (or `err`) for one cycle, then return to IDLE. A request held high is re-accepted in that IDLE cycle, so the control FSM must deassert it after `done`.
- Loads, func3: 0 LB sign-extend byte `addr[1:0]`; 1 LH sign-extend half `addr[1]`; 2 LW; 4 LBU and 5 LHU zero-extend.
- Stores, func3: 0 SB, 1 SH, 2 SW. Byte enables come from `addr[1:0]`, and `wdata` lanes are replicated to the target position. Untouched bytes are preserved.
- Illegal func3 is a rejected request: loads 3/6/7, stores 3–7. Result is `err`, no write, `rdata` unchanged.
- `rdata` is updated only on a successful read completion.

## Timing
- Latency from accept edge to the `done` cycle is `WAIT_CYCLES`+2 cycles; throughput is one request per `WAIT_CYCLES`+3 cycles.
- The write commits on the clock edge leaving ACCESS. `done` follows on the next cycle.
- Reset values: state IDLE; `done`, `err`, `busy` = 0; `rdata` = 0; counter 0. Array contents are not reset.
- Reset mid-operation (ACCESS) aborts the request: no write, no `done`.
- Request inputs are ignored while `busy` is high.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined: LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0, is a rejected request (`err`, no access).
- Undefined: low address bits the size cannot use are ignored. LW/SW force `[1:0]`=0, halfword forces `[0]`=0, and the access completes normally.

## Structure
- Shared package `rv_pkg`:
  - func3 size constants: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`
  - FSM state enum
- Sub-module `mem_array`:
  - synchronous word array, one port, 4-bit byte-write enable, registered read
  - the responder samples its output in RESP

## Test plan
- Reset, then SW `addr`=0x10 `wdata`=0xDEADBEEF, then LW 0x10 -> `done` after `WAIT_CYCLES`+2 cycles; `rdata`=0xDEADBEEF.
- After the above, SB 0x11 `wdata`=0x55, LW 0x10 -> 0xDEAD55EF; LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD.
- `MemoryRead` and `MemoryWrite` both high -> `err` pulse, no `done`; a subsequent LW 0x10 is unchanged.
- LW with func3=3 -> `err`; `rdata` keeps its previous value.
- With `MEM_MISALIGN_TRAP_EN`: LW 0x12 -> `err`. Without it: LW 0x12 -> `rdata` = word at 0x10.
- `WAIT_CYCLES`=3: assert `clr` during ACCESS of SW 0x20 `wdata`=0x1234 -> no `done`, `busy`=0 immediately; LW 0x20 returns the prior contents.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I load/store size constants, responder FSM states and lane helpers
package rv_pkg;
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    function automatic logic load_ok(input logic [2:0] f);
        return f inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    function automatic logic store_ok(input logic [2:0] f);
        return f inside {F3_B, F3_H, F3_W};
    endfunction

    // Byte lanes written by a store; off is already size-aligned.
    function automatic logic [3:0] store_be(input logic [2:0] f, input logic [1:0] off);
        return f == F3_B ? 4'b0001 << off : f == F3_H ? 4'b0011 << off : 4'b1111;
    endfunction

    // Right-aligned store data copied into every lane so byte enables pick the target.
    function automatic logic [31:0] store_data(input logic [31:0] d, input logic [2:0] f);
        return f == F3_B ? {4{d[7:0]}} : f == F3_H ? {2{d[15:0]}} : d;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f, input logic [1:0] off);
        logic [31:0] s;
        s = w >> {off, 3'b000};
        return f == F3_B  ? {{24{s[7]}}, s[7:0]} :
               f == F3_H  ? {{16{s[15]}}, s[15:0]} :
               f == F3_BU ? {24'b0, s[7:0]} :
               f == F3_HU ? {16'b0, s[15:0]} : w;
    endfunction
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port word array with per-byte write enable and registered read
//   clk  in      clock
//   en   in      access this cycle (read always, write lanes per be)
//   be   in [4]  byte write enables
//   idx  in [AW] word index
//   wd   in [32] write data (lane-positioned)
//   rd   out[32] word read at idx, valid the cycle after en
module mem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wd,
    output logic [31:0]   rd
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
            rd <= mem[idx];
        end
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder serving MemoryRead/MemoryWrite from a unified word array
//   clk          in      clock
//   clr          in      asynchronous active-high reset
//   MemoryRead   in      read request (level, sampled in IDLE)
//   MemoryWrite  in      write request (level, sampled in IDLE)
//   addr         in [32] byte address
//   wdata        in [32] right-aligned store data
//   func3        in [3]  RV32I load/store size/sign
//   rdata        out[32] extended load result, held until next read completion
//   done         out     one-cycle completion pulse
//   busy         out     request in flight
//   err          out     one-cycle rejection pulse
// Build option: MEM_MISALIGN_TRAP_EN rejects misaligned half/word accesses instead of
// silently dropping the unusable low address bits.
module mem_responder
    import rv_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        MemoryRead,
    input  logic        MemoryWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  func3,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);

    state_t        state;
    logic [3:0]    cnt;
    logic          wr;
    logic          bad;
    logic [2:0]    f3;
    logic [1:0]    off;
    logic [AW-1:0] idx;
    logic [31:0]   wd_q;
    logic [31:0]   rdata_q;
    logic [31:0]   q;
    logic [31:0]   ld;
    logic          en;
    logic          req;
    logic          legal;
    logic          mis;
    logic [1:0]    off_n;
    logic          unused_addr;

    assign unused_addr = ^addr[31:AW+2];
    assign req   = MemoryRead ^ MemoryWrite;
    assign legal = MemoryWrite ? store_ok(func3) : load_ok(func3);

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis   = func3[1:0] == 2'd1 ? addr[0] : func3[1:0] == 2'd2 ? |addr[1:0] : 1'b0;
    assign off_n = addr[1:0];
`else
    assign mis   = 1'b0;
    assign off_n = func3[1:0] == 2'd2 ? 2'b00 : func3[1:0] == 2'd1 ? {addr[1], 1'b0} : addr[1:0];
`endif

    assign en = state == ACCESS && cnt == 4'd0;
    assign ld = load_ext(q, f3, off);
    // Bypass the freshly read word during RESP so data is valid alongside done.
    assign rdata = (state == RESP && !bad && !wr) ? ld : rdata_q;

    mem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk (clk),
        .en  (en),
        .be  (wr ? store_be(f3, off) : 4'b0000),
        .idx (idx),
        .wd  (store_data(wd_q, f3)),
        .rd  (q)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            wr      <= 1'b0;
            bad     <= 1'b0;
            f3      <= 3'd0;
            off     <= 2'd0;
            idx     <= '0;
            wd_q    <= 32'd0;
            rdata_q <= 32'd0;
            done    <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if ((MemoryRead && MemoryWrite) || (req && (!legal || mis))) begin
                        state <= RESP;
                        bad   <= 1'b1;
                        err   <= 1'b1;
                        busy  <= 1'b1;
                    end else if (req) begin
                        state <= ACCESS;
                        bad   <= 1'b0;
                        busy  <= 1'b1;
                        cnt   <= 4'(WAIT_CYCLES);
                        wr    <= MemoryWrite;
                        f3    <= func3;
                        off   <= off_n;
                        idx   <= addr[AW+1:2];
                        wd_q  <= wdata;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (!bad && !wr) rdata_q <= ld;
                    state <= IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    bad   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
